// File: rtl/rf_sched_pkg.sv
// Shared constants and state encoding for the RF address scheduler.
package rf_sched_pkg;

  localparam int unsigned IA_ROW     = 32;
  localparam int unsigned HW_W       = $clog2(IA_ROW) + 1;
  localparam int unsigned FILT_COLS  = 3;
  localparam int unsigned S_W        = 2;
  localparam int unsigned W_C_LENGTH = 16;
  localparam int unsigned LEN_W      = $clog2(W_C_LENGTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_AG,
    S_ISSUE,
    S_DONE
  } state_t;

endpackage

// File: rtl/rf_sched_idx_counter.sv
// Nested (h, w, s) position counter: s fastest, then w, then h.
module rf_sched_idx_counter
  import rf_sched_pkg::*;
#(
  parameter int unsigned HW_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clear,
  input  logic            i_advance,
  input  logic [HW_W-1:0] i_h_max,
  input  logic [HW_W-1:0] i_w_max,
  input  logic [S_W-1:0]  i_s_max,
  output logic [HW_W-1:0] o_h,
  output logic [HW_W-1:0] o_w,
  output logic [S_W-1:0]  o_s,
  output logic            o_last
);

  logic [HW_W-1:0] h_max_q, w_max_q;
  logic [S_W-1:0]  s_max_q;

  // Limits are captured on clear so later input changes cannot disturb a pass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_max_q <= '0;
      w_max_q <= '0;
      s_max_q <= '0;
      o_h     <= '0;
      o_w     <= '0;
      o_s     <= '0;
    end else if (i_clear) begin
      h_max_q <= i_h_max;
      w_max_q <= i_w_max;
      s_max_q <= i_s_max;
      o_h     <= '0;
      o_w     <= '0;
      o_s     <= '0;
    end else if (i_advance) begin
      if (o_s == s_max_q) begin
        o_s <= '0;
        if (o_w == w_max_q) begin
          o_w <= '0;
          o_h <= o_h + HW_W'(1);
        end else begin
          o_w <= o_w + HW_W'(1);
        end
      end else begin
        o_s <= o_s + S_W'(1);
      end
    end
  end

  // Final position of the sweep.
  always_comb begin
    o_last = (o_s == s_max_q) && (o_w == w_max_q) && (o_h == h_max_q);
  end

endmodule

// File: rtl/rf_addr_scheduler.sv
// Sequences the sparse-weight RF address generator over one layer pass
// and offers each resulting RF vector to the PE array.
module rf_addr_scheduler
  import rf_sched_pkg::*;
#(
  parameter  int unsigned IA_ROW    = rf_sched_pkg::IA_ROW,
  parameter  int unsigned FILT_COLS = rf_sched_pkg::FILT_COLS,
  parameter  int unsigned LEN_W     = rf_sched_pkg::LEN_W,
  localparam int unsigned HW_W      = $clog2(IA_ROW) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [HW_W-1:0]  i_h_size,
  input  logic [HW_W-1:0]  i_w_size,
  input  logic [1:0]       i_s_num,
  input  logic [LEN_W-1:0] i_col_len [0:FILT_COLS-1],
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_ag_start,
  output logic [HW_W-1:0]  o_ag_h,
  output logic [HW_W-1:0]  o_ag_w,
  output logic [1:0]       o_ag_s,
  output logic [LEN_W-1:0] o_ag_length,
  input  logic             i_ag_finish,
  output logic             o_issue_valid,
  input  logic             i_issue_ready
);

  state_t           state_q, state_d;
  logic             abort_pend_q, abort_pend_d;
  logic             idx_clear, idx_adv, idx_last, err_set, cfg_ok;
  logic [HW_W-1:0]  h_idx, w_idx;
  logic [S_W-1:0]   s_idx;
  logic [LEN_W-1:0] col_len_q [0:FILT_COLS-1];
  logic [LEN_W-1:0] cur_len;

  assign cfg_ok = (i_h_size != '0) && (i_h_size <= HW_W'(IA_ROW)) &&
                  (i_w_size != '0) && (i_w_size <= HW_W'(IA_ROW)) &&
                  (i_s_num  != '0) && (i_s_num  <= S_W'(FILT_COLS));

  rf_sched_idx_counter #(
    .HW_W (HW_W)
  ) u_idx (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (idx_clear),
    .i_advance (idx_adv),
    .i_h_max   (i_h_size - HW_W'(1)),
    .i_w_max   (i_w_size - HW_W'(1)),
    .i_s_max   (i_s_num - S_W'(1)),
    .o_h       (h_idx),
    .o_w       (w_idx),
    .o_s       (s_idx),
    .o_last    (idx_last)
  );

  // Column nonzero counts are captured on the accepted start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < FILT_COLS; i++) col_len_q[i] <= '0;
    end else if (idx_clear) begin
      for (int unsigned i = 0; i < FILT_COLS; i++) col_len_q[i] <= i_col_len[i];
    end
  end

  // Length of the column currently addressed by s.
  always_comb begin
    cur_len = '0;
    for (int unsigned i = 0; i < FILT_COLS; i++) begin
      if (32'(s_idx) == i) cur_len = col_len_q[i];
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d      = state_q;
    abort_pend_d = abort_pend_q;
    idx_clear    = 1'b0;
    idx_adv      = 1'b0;
    err_set      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (i_start) begin
          if (cfg_ok) begin
            state_d   = S_LAUNCH;
            idx_clear = 1'b1;
          end else begin
            state_d = S_DONE;
            err_set = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (cur_len == '0) begin
          if (idx_last) state_d = S_DONE;
          else          idx_adv = 1'b1;
        end else begin
          state_d = S_WAIT_AG;
        end
      end
      S_WAIT_AG: begin
        // The generator cannot be stopped: an abort is held until it finishes.
        if (i_ag_finish) begin
          state_d      = (abort_pend_q || i_abort) ? S_IDLE : S_ISSUE;
          abort_pend_d = 1'b0;
        end else if (i_abort) begin
          abort_pend_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_issue_ready) begin
          if (idx_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LAUNCH;
            idx_adv = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status outputs, decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_issue_valid <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_busy        <= state_d inside {S_LAUNCH, S_WAIT_AG, S_ISSUE};
      o_done        <= (state_d == S_DONE);
      o_issue_valid <= (state_d == S_ISSUE);
      if (idx_clear)    o_err <= 1'b0;
      else if (err_set) o_err <= 1'b1;
    end
  end

  assign o_ag_start  = (state_q == S_LAUNCH) && (cur_len != '0);
  assign o_ag_h      = h_idx;
  assign o_ag_w      = w_idx;
  assign o_ag_s      = s_idx;
  assign o_ag_length = cur_len;

endmodule

// File: tb/tb_rf_addr_scheduler.sv
// Randomized self-checking bench for rf_addr_scheduler with a sweep-list
// reference model of the expected launch/issue sequence and its timing.
module tb_rf_addr_scheduler;

  localparam int unsigned HW_W  = 6;
  localparam int unsigned LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             i_start = 1'b0, i_abort = 1'b0;
  logic [HW_W-1:0]  i_h_size = '0, i_w_size = '0;
  logic [1:0]       i_s_num = '0;
  logic [LEN_W-1:0] col_len [0:2];
  logic             o_busy, o_done, o_err, o_ag_start, o_issue_valid;
  logic [HW_W-1:0]  o_ag_h, o_ag_w;
  logic [1:0]       o_ag_s;
  logic [LEN_W-1:0] o_ag_length;
  logic             i_ag_finish = 1'b0, i_issue_ready = 1'b0;

  int nvec = 0, nerr = 0, cyc = 0, ag_rem = 0;

  typedef struct {
    int h; int w; int s; int len; int skip;
  } item_t;

  always #5 clk = ~clk;

  rf_addr_scheduler #(
    .IA_ROW    (32),
    .FILT_COLS (3),
    .LEN_W     (LEN_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_h_size      (i_h_size),
    .i_w_size      (i_w_size),
    .i_s_num       (i_s_num),
    .i_col_len     (col_len),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_ag_start    (o_ag_start),
    .o_ag_h        (o_ag_h),
    .o_ag_w        (o_ag_w),
    .o_ag_s        (o_ag_s),
    .o_ag_length   (o_ag_length),
    .i_ag_finish   (i_ag_finish),
    .o_issue_valid (o_issue_valid),
    .i_issue_ready (i_issue_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_cfg(input int hs, input int ws, input int sn, input int l0, input int l1, input int l2);
    i_h_size   = HW_W'(hs);
    i_w_size   = HW_W'(ws);
    i_s_num    = 2'(sn);
    col_len[0] = LEN_W'(l0);
    col_len[1] = LEN_W'(l1);
    col_len[2] = LEN_W'(l2);
  endtask

  task automatic scramble_cfg();
    set_cfg($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 3),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"},   32'(o_busy), 0);
    check_eq({pfx, "_done"},   32'(o_done), 0);
    check_eq({pfx, "_err"},    32'(o_err), 0);
    check_eq({pfx, "_start"},  32'(o_ag_start), 0);
    check_eq({pfx, "_h"},      32'(o_ag_h), 0);
    check_eq({pfx, "_w"},      32'(o_ag_w), 0);
    check_eq({pfx, "_s"},      32'(o_ag_s), 0);
    check_eq({pfx, "_len"},    32'(o_ag_length), 0);
    check_eq({pfx, "_valid"},  32'(o_issue_valid), 0);
  endtask

  task automatic recover();
    rst_n = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_ag_finish = 1'b0; i_issue_ready = 1'b0;
    ag_rem = 0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One full pass; caller is at a negedge. hold = cycles ready stays low per issue,
  // pct = chance (percent) of ready after that.
  task automatic run_pass(input int hs, input int ws, input int sn,
                          input int l0, input int l1, input int l2,
                          input int hold, input int pct);
    item_t q[$];
    int lens[3];
    int skip, trail, idx, ref_cyc, start_cyc, t_start, phase, wait_n;
    bit bad;
    lens[0] = l0; lens[1] = l1; lens[2] = l2;
    skip = 0;
    for (int h = 0; h < hs; h++)
      for (int w = 0; w < ws; w++)
        for (int s = 0; s < sn; s++)
          if (lens[s] == 0) skip++;
          else begin
            q.push_back('{h, w, s, lens[s], skip});
            skip = 0;
          end
    trail = skip;
    set_cfg(hs, ws, sn, l0, l1, l2);
    i_start   = 1'b1;
    start_cyc = cyc;
    ref_cyc   = cyc;
    idx = 0; phase = 0; wait_n = 0; t_start = 0; bad = 1'b0;
    while (1) begin
      tick();
      i_start = 1'b0;
      i_issue_ready = 1'b0;
      i_ag_finish = 1'b0;
      if (ag_rem > 0) begin
        ag_rem--;
        if (ag_rem == 0) i_ag_finish = 1'b1;
      end
      scramble_cfg();
      if (cyc - ref_cyc > 300) begin
        check_eq("pass_timeout", 0, 1);
        bad = 1'b1;
        break;
      end
      if (cyc == start_cyc + 1) begin
        check_eq("busy_on", 32'(o_busy), 1);
        check_eq("err_clear", 32'(o_err), 0);
      end
      if (idx == q.size()) begin
        if (o_done) begin
          check_eq("done_cyc", cyc, ref_cyc + 1 + trail);
          check_eq("done_busy", 32'(o_busy), 0);
          break;
        end
        if (cyc > ref_cyc + 1 + trail) begin
          check_eq("done_missing", 0, 1);
          bad = 1'b1;
          break;
        end
        continue;
      end
      if (o_done) check_eq("early_done", 1, 0);
      if (phase == 0) begin
        if (o_ag_start) begin
          check_eq("launch_cyc", cyc, ref_cyc + 1 + q[idx].skip);
          check_eq("launch_h", 32'(o_ag_h), q[idx].h);
          check_eq("launch_w", 32'(o_ag_w), q[idx].w);
          check_eq("launch_s", 32'(o_ag_s), q[idx].s);
          check_eq("launch_len", 32'(o_ag_length), q[idx].len);
          t_start = cyc;
          ag_rem  = q[idx].len;
          phase   = 1;
        end else if (cyc >= ref_cyc + 1 + q[idx].skip) begin
          check_eq("launch_missing", 0, 1);
          bad = 1'b1;
          break;
        end
      end else if (phase == 1) begin
        if (o_ag_start) check_eq("extra_ag_start", 1, 0);
        if (o_issue_valid) begin
          check_eq("valid_cyc", cyc, t_start + q[idx].len + 1);
          check_eq("issue_h", 32'(o_ag_h), q[idx].h);
          check_eq("issue_w", 32'(o_ag_w), q[idx].w);
          check_eq("issue_s", 32'(o_ag_s), q[idx].s);
          phase  = 2;
          wait_n = 0;
        end else if (cyc > t_start + q[idx].len + 1) begin
          check_eq("valid_missing", 0, 1);
          bad = 1'b1;
          break;
        end else begin
          i_start = ($urandom_range(0, 7) == 0);
        end
      end
      if (phase == 2) begin
        if (!o_issue_valid) begin
          check_eq("valid_dropped", 0, 1);
          bad = 1'b1;
          break;
        end
        if (wait_n > 0) begin
          check_eq("hold_h", 32'(o_ag_h), q[idx].h);
          check_eq("hold_w", 32'(o_ag_w), q[idx].w);
          check_eq("hold_s", 32'(o_ag_s), q[idx].s);
          check_eq("hold_no_start", 32'(o_ag_start), 0);
        end
        if (wait_n >= hold && $urandom_range(1, 100) <= pct) begin
          i_issue_ready = 1'b1;
          ref_cyc = cyc;
          idx++;
          phase = 0;
        end else begin
          wait_n++;
        end
      end
    end
    i_issue_ready = 1'b0;
    i_start = 1'b0;
    if (bad) begin
      recover();
    end else begin
      tick();
      check_eq("done_width", 32'(o_done), 0);
    end
  endtask

  task automatic run_reject(input int hs, input int ws, input int sn);
    set_cfg(hs, ws, sn, 1, 1, 1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("rej_err", 32'(o_err), 1);
    check_eq("rej_done", 32'(o_done), 1);
    check_eq("rej_busy", 32'(o_busy), 0);
    check_eq("rej_ag_start", 32'(o_ag_start), 0);
    tick();
    check_eq("rej_done_off", 32'(o_done), 0);
    check_eq("rej_err_hold", 32'(o_err), 1);
    check_eq("rej_ag_start2", 32'(o_ag_start), 0);
  endtask

  task automatic run_abort_wait();
    set_cfg(1, 2, 1, 3, 0, 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("abw_launch", 32'(o_ag_start), 1);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check_eq("abw_busy_hold", 32'(o_busy), 1);
    check_eq("abw_valid0", 32'(o_issue_valid), 0);
    tick();
    i_ag_finish = 1'b1;
    check_eq("abw_busy_fin", 32'(o_busy), 1);
    tick();
    i_ag_finish = 1'b0;
    check_eq("abw_idle_busy", 32'(o_busy), 0);
    for (int k = 0; k < 4; k++) begin
      check_eq("abw_no_valid", 32'(o_issue_valid), 0);
      check_eq("abw_no_done", 32'(o_done), 0);
      check_eq("abw_no_start", 32'(o_ag_start), 0);
      tick();
    end
  endtask

  task automatic run_abort_issue();
    set_cfg(1, 1, 1, 1, 0, 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_ag_finish = 1'b1;
    tick();
    i_ag_finish = 1'b0;
    check_eq("abi_valid", 32'(o_issue_valid), 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check_eq("abi_valid_drop", 32'(o_issue_valid), 0);
    check_eq("abi_busy", 32'(o_busy), 0);
    check_eq("abi_no_done", 32'(o_done), 0);
    tick();
    check_eq("abi_no_done2", 32'(o_done), 0);
  endtask

  task automatic run_reset_mid_issue();
    set_cfg(1, 2, 1, 2, 0, 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    i_ag_finish = 1'b1;
    tick();
    i_ag_finish = 1'b0;
    check_eq("rmi_valid1", 32'(o_issue_valid), 1);
    i_issue_ready = 1'b1;
    tick();
    i_issue_ready = 1'b0;
    check_eq("rmi_launch2", 32'(o_ag_start), 1);
    check_eq("rmi_w1", 32'(o_ag_w), 1);
    tick();
    tick();
    i_ag_finish = 1'b1;
    tick();
    i_ag_finish = 1'b0;
    check_eq("rmi_valid2", 32'(o_issue_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rmi");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    col_len[0] = '0; col_len[1] = '0; col_len[2] = '0;
    #2 rst_n = 1'b0;
    #2 check_all_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_pass(2, 2, 3, 2, 1, 3, 0, 100);
    run_pass(1, 1, 3, 0, 2, 0, 0, 100);
    run_pass(2, 1, 2, 3, 1, 0, 5, 100);
    run_reject(1, 0, 2);
    run_pass(1, 2, 1, 2, 0, 0, 0, 100);
    run_reject(33, 1, 1);
    run_reject(2, 2, 0);
    run_pass(1, 1, 1, 1, 0, 0, 0, 100);
    run_abort_wait();
    run_pass(2, 1, 1, 1, 0, 0, 0, 100);
    run_abort_issue();
    run_pass(1, 1, 2, 1, 1, 0, 0, 100);
    run_reset_mid_issue();
    run_pass(1, 2, 2, 1, 2, 0, 0, 100);
    run_pass(1, 1, 3, 0, 0, 0, 0, 100);

    for (int n = 0; n < 25; n++) begin
      int ln[3];
      for (int k = 0; k < 3; k++)
        ln[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      run_pass($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3),
               ln[0], ln[1], ln[2], $urandom_range(0, 2), $urandom_range(30, 100));
    end

    run_pass(32, 32, 1, 1, 0, 0, 0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
